edge_gen: RTL

Transmit-side counterpart of the edge detector: generates a programmed burst of clean pulses, each producing one rising and one falling edge, on a single-bit line.
Used to drive trigger and strobe lines and to stimulate edge-detect logic in loopback.
One start request produces num_pulses pulses with programmable active/inactive lengths and a selectable idle level.
Reports busy, a done pulse, and a per-edge marker.

---
 rtl/edge_gen_pkg.sv | 18 +
 rtl/edge_gen_cnt.sv | 29 ++
 rtl/edge_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/edge_gen_pkg.sv
// rtl/edge_gen_pkg.sv - shared constants, state encoding and length helper for edge_gen
package edge_gen_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int NUM_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_ACTIVE   = 2'd1;
  localparam state_t ST_INACTIVE = 2'd2;

  // Phase counters count down to zero, so a length of N loads N-1; 0 behaves as 1.
  function automatic logic [31:0] eff_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd0 : len - 32'd1;
  endfunction

endpackage

// File: rtl/edge_gen_cnt.sv
// rtl/edge_gen_cnt.sv - loadable down-counter with zero flag for phase timing
module edge_gen_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/edge_gen.sv
// rtl/edge_gen.sv - programmable pulse-burst generator with busy, done and edge marker
module edge_gen
  import edge_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic             idle_level,
  input  logic             abort,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic             edge_p
);

  state_t           state, state_nxt;
  logic [NUM_W-1:0] pulse_cnt, pulse_nxt;
  logic [CNT_W-1:0] high_lat, low_lat;
  logic             idle_lat;

  logic             dout_nxt, busy_nxt, done_nxt, edge_nxt;
  logic             cfg_latch;
  logic             ph_clr, ph_load, ph_dec, ph_zero;
  logic [CNT_W-1:0] ph_val, ph_count;

  edge_gen_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .srst     (srst),
    .clr      (ph_clr),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .count    (ph_count),
    .zero     (ph_zero)
  );

  always_comb begin
    state_nxt = state;
    dout_nxt  = dout;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    edge_nxt  = 1'b0;
    pulse_nxt = pulse_cnt;
    cfg_latch = 1'b0;
    ph_clr    = 1'b0;
    ph_load   = 1'b0;
    ph_dec    = 1'b0;
    ph_val    = '0;

    case (state)
      ST_IDLE: begin
        dout_nxt = idle_level;
        busy_nxt = 1'b0;
        if (start && !abort) begin
          cfg_latch = 1'b1;
          if (num_pulses != '0) begin
            state_nxt = ST_ACTIVE;
            dout_nxt  = ~idle_level;
            busy_nxt  = 1'b1;
            ph_load   = 1'b1;
            ph_val    = CNT_W'(eff_len(32'(high_len)));
            pulse_nxt = num_pulses - NUM_W'(1);
          end else begin
            done_nxt  = 1'b1;
          end
        end
      end

      ST_ACTIVE, ST_INACTIVE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          dout_nxt  = idle_lat;
          busy_nxt  = 1'b0;
          ph_clr    = 1'b1;
          pulse_nxt = '0;
        end else if (!ph_zero) begin
          ph_dec = 1'b1;
        end else if (state == ST_INACTIVE) begin
          state_nxt = ST_ACTIVE;
          dout_nxt  = ~idle_lat;
          ph_load   = 1'b1;
          ph_val    = CNT_W'(eff_len(32'(high_lat)));
        end else if (pulse_cnt != '0) begin
          state_nxt = ST_INACTIVE;
          dout_nxt  = idle_lat;
          ph_load   = 1'b1;
          ph_val    = CNT_W'(eff_len(32'(low_lat)));
          pulse_nxt = pulse_cnt - NUM_W'(1);
        end else begin
          // Last pulse ends straight into idle: no trailing inactive phase.
          state_nxt = ST_IDLE;
          dout_nxt  = idle_lat;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        dout_nxt  = idle_lat;
        busy_nxt  = 1'b0;
        ph_clr    = 1'b1;
        pulse_nxt = '0;
      end
    endcase

    // Idle-level tracking while resting in IDLE is not a generated edge.
    if ((state != ST_IDLE) || (state_nxt != ST_IDLE)) begin
      edge_nxt = dout_nxt ^ dout;
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state     <= ST_IDLE;
      dout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      edge_p    <= 1'b0;
      pulse_cnt <= '0;
      high_lat  <= '0;
      low_lat   <= '0;
      idle_lat  <= 1'b0;
    end else begin
      state     <= state_nxt;
      dout      <= dout_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      edge_p    <= edge_nxt;
      pulse_cnt <= pulse_nxt;
      if (cfg_latch) begin
        high_lat <= high_len;
        low_lat  <= low_len;
        idle_lat <= idle_level;
      end
    end
  end

endmodule
